int_div_32by16: RTL and testbench

INT_DIV_32BY16 -- requirements
Module: int_div_32by16

---
 rtl/int_div_pkg.sv | 48 ++++
 rtl/int_div_32by16.sv | 181 ++++++++++++++++++
 tb/tb_int_div_32by16.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/int_div_pkg.sv
// ----------------------------------------------------------------------------
// int_div_pkg
// Shared definitions for the 32-by-16 sequential integer divider.
//   - state_t        : divider FSM states
//   - *_W            : fixed operand / result widths
//   - ITERATIONS     : number of shift-subtract steps per divide
//   - LAST_ITER      : counter value on which the final step is taken
//   - magnitude32/16 : helpers returning |x| for optionally signed operands
// ----------------------------------------------------------------------------
package int_div_pkg;

    localparam int DIVIDEND_W = 32;
    localparam int DIVISOR_W  = 16;
    localparam int QUOT_W     = 32;
    localparam int REM_W      = 16;
    // Partial remainder is one bit wider than the divisor so the shifted
    // value can be compared against a full 16-bit unsigned divisor.
    localparam int PREM_W     = DIVISOR_W + 1;
    localparam int ITERATIONS = 32;
    localparam int CNT_W      = 5;

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITERATIONS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Unsigned magnitude of a possibly two's-complement value. The result
    // width equals the operand width, so the most negative value maps to
    // 2^(W-1) as an unsigned number.
    function automatic logic [DIVIDEND_W-1:0] magnitude32(
        input logic [DIVIDEND_W-1:0] x,
        input logic                  is_signed
    );
        return (is_signed && x[DIVIDEND_W-1]) ? -x : x;
    endfunction

    function automatic logic [DIVISOR_W-1:0] magnitude16(
        input logic [DIVISOR_W-1:0] x,
        input logic                 is_signed
    );
        return (is_signed && x[DIVISOR_W-1]) ? -x : x;
    endfunction

endpackage

// File: rtl/int_div_32by16.sv
// ----------------------------------------------------------------------------
// int_div_32by16
// Sequential 32-bit by 16-bit integer divider, signed or unsigned, using a
// restoring shift-subtract algorithm (one quotient bit per clock, MSB first).
// Signed results truncate toward zero; the remainder takes the dividend sign.
// Division by zero returns Q = all ones, R = A[15:0] and raises div0.
//
// Ports
//   clk   in   1   rising-edge clock
//   rst   in   1   asynchronous active-high reset
//   start in   1   divide request, honoured only in IDLE
//   A     in  32   dividend, captured on the accepting edge
//   B     in  16   divisor, captured on the accepting edge
//   sign  in   1   1 = two's-complement divide, 0 = unsigned
//   busy  out  1   high while a divide is in progress
//   done  out  1   one-cycle pulse; Q/R/div0 valid while high
//   Q     out 32   quotient, held until overwritten or reset
//   R     out 16   remainder, held until overwritten or reset
//   div0  out  1   the current result came from a zero divisor
//
// Timing (accept on edge N): done is high from N+34 to N+35 for B != 0 and
// from N+1 to N+2 for B == 0. busy and done are registered copies of the
// FSM state, so each lags the state by one edge.
// ----------------------------------------------------------------------------
module int_div_32by16
    import int_div_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] A,
    input  logic [DIVISOR_W-1:0]  B,
    input  logic                  sign,
    output logic                  busy,
    output logic                  done,
    output logic [QUOT_W-1:0]     Q,
    output logic [REM_W-1:0]      R,
    output logic                  div0
);

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_t                state_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [REM_W-1:0]      rem_q;    // settled partial remainder (< divisor)
    logic [QUOT_W-1:0]     quo_q;    // dividend bits shift out, quotient in
    logic [DIVISOR_W-1:0]  bmag_q;   // |B| (or B when unsigned)
    logic                  neg_quo_q;
    logic                  neg_rem_q;

    logic                  busy_q;
    logic                  done_q;
    logic [QUOT_W-1:0]     q_q;
    logic [REM_W-1:0]      r_q;
    logic                  div0_q;

    // ------------------------------------------------------------------
    // Combinational next values
    // ------------------------------------------------------------------
    logic [DIVIDEND_W-1:0] a_mag;
    logic [DIVISOR_W-1:0]  b_mag;
    logic [PREM_W-1:0]     rem_shift;
    logic                  rem_ge;
    logic [REM_W-1:0]      rem_d;
    logic [QUOT_W-1:0]     quo_d;
    logic [QUOT_W-1:0]     q_fix;
    logic [REM_W-1:0]      r_fix;

    always_comb begin
        // NOTE: every variable written here gets a value on every path,
        // starting with these defaults, so no latch can be inferred.
        a_mag     = '0;
        b_mag     = '0;
        rem_shift = '0;
        rem_ge    = 1'b0;
        rem_d     = '0;
        quo_d     = '0;
        q_fix     = '0;
        r_fix     = '0;

        // Operand magnitudes for the accepting edge.
        a_mag = magnitude32(A, sign);
        b_mag = magnitude16(B, sign);

        // One restoring step: bring down the next dividend bit, subtract the
        // divisor if it fits. The remainder before the step is below the
        // divisor, so the restored/subtracted result always fits 16 bits.
        rem_shift = {rem_q, quo_q[QUOT_W-1]};
        rem_ge    = (rem_shift >= {1'b0, bmag_q});
        rem_d     = REM_W'(rem_ge ? (rem_shift - {1'b0, bmag_q}) : rem_shift);
        quo_d     = {quo_q[QUOT_W-2:0], rem_ge};

        // Sign correction. Negating a quotient magnitude of 2^31 wraps back
        // to 32'h8000_0000, which is the intended result for MIN / -1.
        q_fix = neg_quo_q ? -quo_q : quo_q;
        r_fix = neg_rem_q ? -rem_q : rem_q;
    end

    // ------------------------------------------------------------------
    // FSM, datapath and registered outputs
    // ------------------------------------------------------------------
    // NOTE: all state below is updated with non-blocking assignments so
    // every register samples the pre-edge values of the others.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            bmag_q    <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            q_q       <= '0;
            r_q       <= '0;
            div0_q    <= 1'b0;
        end else begin
            // Status outputs mirror the current state one edge later.
            busy_q <= (state_q == DIV) || (state_q == FIX);
            done_q <= (state_q == DONE);

            case (state_q)
                IDLE: begin
                    if (start) begin
                        neg_quo_q <= sign & (A[DIVIDEND_W-1] ^ B[DIVISOR_W-1]);
                        neg_rem_q <= sign & A[DIVIDEND_W-1];
                        cnt_q     <= '0;
                        rem_q     <= '0;
                        if (B == '0) begin
                            // Zero divisor: the result is fixed, skip DIV/FIX.
                            q_q     <= '1;
                            r_q     <= A[REM_W-1:0];
                            div0_q  <= 1'b1;
                            quo_q   <= '0;
                            bmag_q  <= '0;
                            state_q <= DONE;
                        end else begin
                            quo_q   <= a_mag;
                            bmag_q  <= b_mag;
                            state_q <= DIV;
                        end
                    end
                end

                DIV: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    cnt_q <= cnt_q + CNT_W'(1);
                    // Counter wraps to zero on the last step.
                    if (cnt_q == LAST_ITER) begin
                        state_q <= FIX;
                    end
                end

                FIX: begin
                    q_q     <= q_fix;
                    r_q     <= r_fix;
                    div0_q  <= 1'b0;
                    state_q <= DONE;
                end

                DONE: begin
                    state_q <= IDLE;
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign Q    = q_q;
    assign R    = r_q;
    assign div0 = div0_q;

endmodule

// File: tb/tb_int_div_32by16.sv
// ----------------------------------------------------------------------------
// tb_int_div_32by16
// Directed and randomised checks of int_div_32by16. Expected results are
// queued when a divide is issued and popped when done is observed.
// ----------------------------------------------------------------------------
module tb_int_div_32by16;

    typedef struct packed {
        logic [31:0] q;
        logic [15:0] r;
        logic        z;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] A;
    logic [15:0] B;
    logic        sign;
    logic        busy;
    logic        done;
    logic [31:0] Q;
    logic [15:0] R;
    logic        div0;

    int   checks = 0;
    int   fails  = 0;
    exp_t sb_q[$];

    int_div_32by16 dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .A    (A),
        .B    (B),
        .sign (sign),
        .busy (busy),
        .done (done),
        .Q    (Q),
        .R    (R),
        .div0 (div0)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Independent reference: SV integer division truncates toward zero and
    // the remainder follows the dividend sign.
    function automatic exp_t model(input logic [31:0] a, input logic [15:0] b, input logic s);
        exp_t e;
        logic signed [31:0] sa32;
        logic signed [15:0] sb16;
        longint na, nb, nq, nr;
        if (b == 16'd0) begin
            e.q = 32'hFFFF_FFFF;
            e.r = a[15:0];
            e.z = 1'b1;
            return e;
        end
        if (s) begin
            sa32 = a;
            sb16 = b;
            na   = sa32;
            nb   = sb16;
        end else begin
            na = longint'({32'd0, a});
            nb = longint'({48'd0, b});
        end
        nq  = na / nb;
        nr  = na % nb;
        e.q = nq[31:0];
        e.r = nr[15:0];
        e.z = 1'b0;
        return e;
    endfunction

    // Wait for done, counting edges after the accepting edge.
    task automatic wait_done(input int budget, output int lat, output logic first_busy);
        lat        = -1;
        first_busy = 1'bx;
        for (int k = 1; k <= budget; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) first_busy = busy;
            if (done) begin
                lat = k;
                return;
            end
        end
    endtask

    task automatic check_result(input string tag);
        exp_t e;
        checks++;
        assert (sb_q.size() > 0) else begin
            fails++;
            $error("FAIL %s_sb: observed empty queue expected an entry", tag);
        end
        if (sb_q.size() == 0) return;
        e = sb_q.pop_front();
        check({tag, "_q"}, Q, e.q);
        check({tag, "_r"}, {16'd0, R}, {16'd0, e.r});
        check({tag, "_div0"}, {31'd0, div0}, {31'd0, e.z});
    endtask

    task automatic run_op(input string tag, input logic [31:0] a, input logic [15:0] b,
                          input logic s, input exp_t e);
        int   lat;
        logic fb;
        int   exp_lat;
        exp_lat = (b == 16'd0) ? 1 : 34;
        sb_q.push_back(e);
        @(negedge clk);
        A     = a;
        B     = b;
        sign  = s;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        A     = $urandom;
        B     = 16'($urandom);
        sign  = 1'($urandom);
        wait_done(60, lat, fb);
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_busy1"}, {31'd0, fb}, {31'd0, (b != 16'd0)});
        check({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
        check_result(tag);
        @(posedge clk);
        #1;
        check({tag, "_pulse"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        int   lat;
        int   ndone;
        int   first;
        logic fb;
        logic [31:0] ra;
        logic [15:0] rb;
        logic        rs;

        rst   = 1'b1;
        start = 1'b0;
        A     = '0;
        B     = '0;
        sign  = 1'b0;
        #2;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_q", Q, 32'd0);
        check("rst_r", {16'd0, R}, 32'd0);
        check("rst_div0", {31'd0, div0}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed vectors with hand-derived results.
        run_op("u100_7", 32'd100, 16'd7, 1'b0, '{q: 32'd14, r: 16'd2, z: 1'b0});
        run_op("s-100_7", 32'hFFFF_FF9C, 16'h0007, 1'b1, '{q: 32'hFFFF_FFF2, r: 16'hFFFE, z: 1'b0});
        run_op("u_ffff", 32'h0001_0000, 16'hFFFF, 1'b0, '{q: 32'h0000_0001, r: 16'h0001, z: 1'b0});
        run_op("s_ffff", 32'h0001_0000, 16'hFFFF, 1'b1, '{q: 32'hFFFF_0000, r: 16'h0000, z: 1'b0});
        run_op("mul_rt", 32'h0626_0060, 16'h5678, 1'b0, '{q: 32'h0000_1234, r: 16'h0000, z: 1'b0});
        run_op("div0", 32'h1234_5678, 16'h0000, 1'b0, '{q: 32'hFFFF_FFFF, r: 16'h5678, z: 1'b1});
        run_op("min_m1", 32'h8000_0000, 16'hFFFF, 1'b1, '{q: 32'h8000_0000, r: 16'h0000, z: 1'b0});
        run_op("s_rem_neg", 32'hFFFF_FFF9, 16'hFFFE, 1'b1, '{q: 32'h0000_0003, r: 16'hFFFF, z: 1'b0});
        run_op("s_bmin", 32'h7FFF_FFFF, 16'h8000, 1'b1, model(32'h7FFF_FFFF, 16'h8000, 1'b1));
        run_op("u_max", 32'hFFFF_FFFF, 16'h0001, 1'b0, '{q: 32'hFFFF_FFFF, r: 16'h0000, z: 1'b0});

        // Randomised operands against the reference model.
        for (int i = 0; i < 8; i++) begin
            ra = $urandom;
            rb = 16'($urandom);
            rs = i[0];
            if (i == 5) rb = 16'd0;
            run_op($sformatf("rnd%0d", i), ra, rb, rs, model(ra, rb, rs));
        end

        // start pulsed while busy is ignored.
        sb_q.push_back(model(32'd5000, 16'd9, 1'b0));
        @(negedge clk);
        A = 32'd5000; B = 16'd9; sign = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        A = 32'd77; B = 16'd3; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        ndone = 0;
        first = -1;
        for (int k = 6; k <= 50; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                ndone++;
                if (first < 0) begin
                    first = k;
                    check_result("ignore");
                end
            end
        end
        check("ignore_ndone", 32'(ndone), 32'd1);
        check("ignore_lat", 32'(first), 32'd34);

        // Reset during DIV aborts the request.
        @(negedge clk);
        A = 32'd1000; B = 16'd3; sign = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_q", Q, 32'd0);
        check("abort_r", {16'd0, R}, 32'd0);
        check("abort_div0", {31'd0, div0}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        check("abort_nodone", 32'(ndone), 32'd0);
        run_op("after_abort", 32'd1000, 16'd3, 1'b0, '{q: 32'd333, r: 16'd1, z: 1'b0});

        // start held high through DONE: second divide accepted on the first
        // IDLE cycle after done.
        sb_q.push_back('{q: 32'd20, r: 16'd0, z: 1'b0});
        sb_q.push_back('{q: 32'hFFFF_FFFD, r: 16'hFFFF, z: 1'b0});
        @(negedge clk);
        A = 32'd200; B = 16'd10; sign = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        A = 32'hFFFF_FFF6; B = 16'd3; sign = 1'b1;
        wait_done(60, lat, fb);
        check("b2b_lat1", 32'(lat), 32'd34);
        check_result("b2b_1");
        @(posedge clk);
        #1;
        start = 1'b0;
        check("b2b_busy_accept", {31'd0, busy}, 32'd0);
        wait_done(60, lat, fb);
        check("b2b_lat2", 32'(lat), 32'd34);
        check_result("b2b_2");

        $display("[TB] %0d tests run, %0d failed", checks, fails);
        $finish;
    end

endmodule
